// File: rtl/sram_controller_if.sv
// Pipeline-side handshake bundle for sram_controller.
//
// Signals:
//   rd_en      load request, held by the MEM stage until ready
//   wr_en      store request, held by the MEM stage until ready
//   address    32-bit byte address (ALU result)
//   write_data 32-bit store data
//   read_data  32-bit registered load result
//   ready      0 freezes the pipeline
//
// Modports:
//   master  the MEM stage side (drives requests)
//   slave   the controller side (drives read_data/ready)
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// Sequences the DE2 16-bit asynchronous SRAM for the MEM stage. Each 32-bit
// load/store becomes two half-word accesses (low half first), each lasting
// ACCESS_CYCLES clocks. ready stays low while the access is in flight so the
// pipeline freezes, then pulses high for one DONE cycle.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   bus        pipeline handshake (slave modport of sram_controller_if)
//   SRAM_DQ    bidirectional SRAM data bus
//   SRAM_ADDR  SRAM half-word address
//   SRAM_UB_N  upper-byte mask (always enabled)
//   SRAM_LB_N  lower-byte mask (always enabled)
//   SRAM_WE_N  write enable, active-low
//   SRAM_CE_N  chip enable, active-low
//   SRAM_OE_N  output enable, active-low
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_controller_if.slave     bus,
    inout  wire  [15:0]          SRAM_DQ,
    output logic [17:0]          SRAM_ADDR,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       read_data_q, read_data_d;
    logic [17:0]       sram_addr_q, sram_addr_d;

    logic [31:0]       addr_off;
    logic              unused_addr_bits;
    logic              cnt_last;
    logic              in_phase;
    logic              dq_oe;
    logic [15:0]       dq_out;

    // Only bits [18:2] of the rebased address select an SRAM word.
    assign addr_off         = bus.address - 32'(BASE_ADDR);
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    assign cnt_last = (cnt_q == CntLast);
    assign in_phase = (state_q == StLow) || (state_q == StHigh);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.rd_en || bus.wr_en) begin
                    op_wr_d     = bus.wr_en;  // write wins when both are set
                    wdata_d     = bus.write_data;
                    sram_addr_d = {addr_off[18:2], 1'b0};
                    cnt_d       = '0;
                    state_d     = StLow;
                end
            end
            StLow: begin
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        read_data_d[15:0] = SRAM_DQ;
                    end
                    sram_addr_d[0] = 1'b1;
                    cnt_d          = '0;
                    state_d        = StHigh;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        read_data_d[31:16] = SRAM_DQ;
                    end
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // The pipeline advances on this edge, so never re-serve here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; purely from registered state so reset forces pins idle
    // without waiting for a clock.
    always_comb begin
        bus.ready = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];

        if (state_q == StIdle) begin
            bus.ready = ~(bus.rd_en | bus.wr_en);
        end else if (state_q == StDone) begin
            bus.ready = 1'b1;
        end

        if (in_phase) begin
            SRAM_CE_N = 1'b0;
            if (op_wr_q) begin
                // WE_N rises on the last phase cycle so the address is held
                // stable across the whole write pulse.
                SRAM_WE_N = cnt_last;
                dq_oe     = 1'b1;
                dq_out    = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_ADDR     = sram_addr_q;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign bus.read_data = read_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

endmodule
